// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: load funct3 encodings,
// skid-buffer state encoding and the write-back beat layout.
package mem_wb_pkg;

  // RISC-V load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Default datapath widths of the core
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;

  // Occupancy of the output/skid register pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Write-back beat at the core's default widths. The pipe re-declares the
  // same layout locally so that non-default XLEN/REG_AW builds stay exact.
  typedef struct packed {
    logic                  wreg;
    logic [REG_AW_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]   wdata;
  } beat_t;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM-side and WB-side signals of mem_wb_pipe grouped as one bundle.
// slave = the pipe stage, master = whatever drives the MEM beats and
// consumes WB beats. Optional macro: MEM_WB_BYPASS_EN adds the bypass outputs.
interface mem_wb_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              i_mem_valid;
  logic              o_mem_ready;
  logic              i_mem_mem2reg;
  logic              i_mem_wreg;
  logic [REG_AW-1:0] i_mem_rd;
  logic [XLEN-1:0]   i_mem_data;
  logic [XLEN-1:0]   i_rd_dmem;
  logic [2:0]        i_mem_funct3;
  logic [1:0]        i_mem_addr_lo;
  logic              i_flush;
  logic              o_wb_valid;
  logic              i_wb_ready;
  logic              o_wb_wreg;
  logic [REG_AW-1:0] o_wb_rd;
  logic [XLEN-1:0]   o_wb_wdata;
`ifdef MEM_WB_BYPASS_EN
  logic              o_byp_valid;
  logic [REG_AW-1:0] o_byp_rd;
  logic [XLEN-1:0]   o_byp_wdata;

  modport slave (
    input  i_mem_valid, i_mem_mem2reg, i_mem_wreg, i_mem_rd, i_mem_data,
           i_rd_dmem, i_mem_funct3, i_mem_addr_lo, i_flush, i_wb_ready,
    output o_mem_ready, o_wb_valid, o_wb_wreg, o_wb_rd, o_wb_wdata,
           o_byp_valid, o_byp_rd, o_byp_wdata
  );

  modport master (
    output i_mem_valid, i_mem_mem2reg, i_mem_wreg, i_mem_rd, i_mem_data,
           i_rd_dmem, i_mem_funct3, i_mem_addr_lo, i_flush, i_wb_ready,
    input  o_mem_ready, o_wb_valid, o_wb_wreg, o_wb_rd, o_wb_wdata,
           o_byp_valid, o_byp_rd, o_byp_wdata
  );
`else
  modport slave (
    input  i_mem_valid, i_mem_mem2reg, i_mem_wreg, i_mem_rd, i_mem_data,
           i_rd_dmem, i_mem_funct3, i_mem_addr_lo, i_flush, i_wb_ready,
    output o_mem_ready, o_wb_valid, o_wb_wreg, o_wb_rd, o_wb_wdata
  );

  modport master (
    output i_mem_valid, i_mem_mem2reg, i_mem_wreg, i_mem_rd, i_mem_data,
           i_rd_dmem, i_mem_funct3, i_mem_addr_lo, i_flush, i_wb_ready,
    input  o_mem_ready, o_wb_valid, o_wb_wreg, o_wb_rd, o_wb_wdata
  );
`endif
endinterface

// File: rtl/mem_wb_load_align.sv
// RISC-V load alignment: picks the byte/halfword addressed by addr_lo out of
// the raw memory word and sign- or zero-extends it to XLEN. Word loads and
// unknown funct3 values pass the raw word through untouched.
module mem_wb_load_align
  import mem_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane addressed by the low address bits
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
  end

  // Halfword lane; addr_lo[0] does not take part in halfword selection
  always_comb begin
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extension according to load type
  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: resolves write-back data (aligned load or ALU
// result) and x0-qualified write enable at the input, then holds beats in
// an output register backed by one skid register so that o_mem_ready can be
// a flop with no path from i_wb_ready. Synchronous flush empties the stage.
// Optional macro: MEM_WB_BYPASS_EN adds o_byp_valid/o_byp_rd/o_byp_wdata.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  mem_wb_pipe_if.slave  bus
);

  typedef struct packed {
    logic              wreg;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
  } pipe_beat_t;

  buf_state_e      state_q, state_d;
  pipe_beat_t      out_q, out_d;
  pipe_beat_t      skid_q, skid_d;
  logic            ready_q;
  logic [XLEN-1:0] load_data;
  pipe_beat_t      in_beat;
  logic            wb_valid;
  logic            accept;
  logic            rel;

  mem_wb_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i   (bus.i_rd_dmem),
    .funct3_i  (bus.i_mem_funct3),
    .addr_lo_i (bus.i_mem_addr_lo),
    .data_o    (load_data)
  );

  // Incoming beat with final write data and x0-suppressed write enable
  always_comb begin
    in_beat.wreg  = bus.i_mem_wreg && (bus.i_mem_rd != '0);
    in_beat.rd    = bus.i_mem_rd;
    in_beat.wdata = bus.i_mem_mem2reg ? load_data : bus.i_mem_data;
  end

  assign wb_valid = (state_q != ST_EMPTY);
  assign accept   = bus.i_mem_valid && ready_q;
  assign rel      = wb_valid && bus.i_wb_ready;

  // Buffer occupancy and data movement; flush overrides every other event
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (bus.i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = in_beat;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && rel) begin
            out_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = ST_FULL;
          end else if (rel) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (rel) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, data registers and the registered ready (mirrors next state != FULL)
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  assign bus.o_mem_ready = ready_q;
  assign bus.o_wb_valid  = wb_valid;
  assign bus.o_wb_wreg   = wb_valid && out_q.wreg;
  assign bus.o_wb_rd     = out_q.rd;
  assign bus.o_wb_wdata  = out_q.wdata;

`ifdef MEM_WB_BYPASS_EN
  // Unregistered view of the current MEM beat for EX forwarding
  assign bus.o_byp_valid = bus.i_mem_valid && in_beat.wreg;
  assign bus.o_byp_rd    = in_beat.rd;
  assign bus.o_byp_wdata = in_beat.wdata;
`endif

endmodule
